// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A fetch entry bundles a fetched word with its PC and the PC of the next instruction.
package fetch_pkg;

   localparam int FETCH_XLEN  = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [FETCH_XLEN-1:0] PC_ALIGN_MASK = {{(FETCH_XLEN-2){1'b1}}, 2'b00};

   typedef struct packed {
      logic [31:0]           instr;
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries between the IMEM response path and decode.
// Flush wins over push; pop on empty and push on full (without pop) are ignored.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  wdata,
   input  logic          pop,
   output fetch_entry_t  rdata,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_unit_q.sv
// IF stage: PC generation, pipelined IMEM requests with credit-based issue, in-order fetch queue.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetched/dropped event counters.
module fetch_unit_q
   import fetch_pkg::*;
#(
   parameter int              XLEN     = FETCH_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              FQ_DEPTH = 4,
   parameter int              MAX_OUT  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            ValidD,
   input  logic            ReadyD,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_dropped_o
`endif
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [OW-1:0]   outstanding_q, outstanding_d;
   logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0] tag_mem_q [MAX_OUT];
   logic [XLEN-1:0] tag_mem_d [MAX_OUT];
   logic [TW-1:0]   tag_rd_q, tag_rd_d;
   logic [TW-1:0]   tag_wr_q, tag_wr_d;

   logic            granted, resp, discard, fq_push, fq_pop;
   logic            fq_empty, fq_full;
   logic [CW-1:0]   fq_count;
   logic [XLEN-1:0] tag_head;
   fetch_entry_t    fq_wdata, fq_rdata;

   function automatic logic [TW-1:0] tag_ptr_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
   endfunction

   // Credits cover queued and in-flight entries, so every response has a free slot.
   assign imem_req_o  = !rst && !PCSrcE
                        && (int'(outstanding_q) < MAX_OUT)
                        && ((int'(fq_count) + int'(outstanding_q)) < FQ_DEPTH);
   assign imem_addr_o = pc_q;

   assign tag_head = tag_mem_q[tag_rd_q];
   assign granted  = imem_req_o && imem_gnt_i;
   assign resp     = imem_rvalid_i && (outstanding_q != '0);
   assign discard  = resp && (PCSrcE || (drop_cnt_q != '0));
   assign fq_push  = resp && !discard;
   assign fq_pop   = ValidD && ReadyD;

   always_comb begin
      fq_wdata          = '0;
      fq_wdata.instr    = imem_rdata_i;
      fq_wdata.pc       = tag_head;
      fq_wdata.pc_plus4 = tag_head + XLEN'(INSTR_BYTES);
   end

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      tag_mem_d     = tag_mem_q;
      tag_rd_d      = tag_rd_q;
      tag_wr_d      = tag_wr_q;

      if (granted) begin
         tag_mem_d[tag_wr_q] = pc_q;
         tag_wr_d            = tag_ptr_inc(tag_wr_q);
         pc_d                = pc_q + XLEN'(INSTR_BYTES);
      end
      if (resp) begin
         tag_rd_d = tag_ptr_inc(tag_rd_q);
      end

      case ({granted, resp})
         2'b10:   outstanding_d = outstanding_q + OW'(1);
         2'b01:   outstanding_d = outstanding_q - OW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      // Every request still in flight after a redirect is stale, including ones already marked.
      if (PCSrcE) begin
         pc_d       = PCTargetE & XLEN'(PC_ALIGN_MASK);
         drop_cnt_d = outstanding_q - OW'(resp);
      end else if (resp && (drop_cnt_q != '0)) begin
         drop_cnt_d = drop_cnt_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         tag_rd_q      <= '0;
         tag_wr_q      <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         tag_rd_q      <= tag_rd_d;
         tag_wr_q      <= tag_wr_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk   (clk),
      .rst   (rst),
      .flush (PCSrcE),
      .push  (fq_push),
      .wdata (fq_wdata),
      .pop   (fq_pop),
      .rdata (fq_rdata),
      .count (fq_count),
      .empty (fq_empty),
      .full  (fq_full)
   );

   assign ValidD   = !rst && !fq_empty;
   assign InstrD   = ValidD ? fq_rdata.instr : '0;
   assign PCD      = ValidD ? XLEN'(fq_rdata.pc) : '0;
   assign PCPlus4D = ValidD ? XLEN'(fq_rdata.pc_plus4) : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_dropped_q, perf_dropped_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_dropped_d = perf_dropped_q;
      if (fq_push && (perf_fetched_q != '1)) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      if (discard && (perf_dropped_q != '1)) begin
         perf_dropped_d = perf_dropped_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_dropped_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_dropped_q <= perf_dropped_d;
      end
   end

   assign perf_fetched_o = perf_fetched_q;
   assign perf_dropped_o = perf_dropped_q;
`endif

   a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
      imem_rvalid_i |-> (outstanding_q != '0));

   a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
      fq_push |-> (!fq_full || fq_pop));

endmodule

// File: tb/tb_fetch_unit_q.sv
// Scoreboard bench for fetch_unit_q: a behavioural memory and PC-stream model predict what decode must see.
// Directed phases (reset, streaming, backpressure, redirects, mid-run reset) surround a randomized phase.
module tb_fetch_unit_q;

   localparam logic [31:0] RESET_PC = 32'h100;
   localparam int          FQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;

   logic        clk;
   logic        rst;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        ValidD;
   logic        ReadyD;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_o;
   logic [31:0] perf_dropped_o;
`endif

   fetch_unit_q #(
      .XLEN     (32),
      .RESET_PC (RESET_PC),
      .FQ_DEPTH (FQ_DEPTH),
      .MAX_OUT  (MAX_OUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .PCSrcE        (PCSrcE),
      .PCTargetE     (PCTargetE),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .ValidD        (ValidD),
      .ReadyD        (ReadyD),
      .InstrD        (InstrD),
      .PCD           (PCD),
      .PCPlus4D      (PCPlus4D)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched_o (perf_fetched_o),
      .perf_dropped_o (perf_dropped_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } expEntry_t;

   typedef struct {
      logic [31:0] addr;
      int          readyCyc;
   } memReq_t;

   expEntry_t   expQ[$];
   memReq_t     memQ[$];
   logic [31:0] modelPc;
   int          cyc;
   int          lastReady;
   logic        prevRst;
   logic        prevRedir;
   int          checks;
   int          fails;
   int          popCnt;
   int          firstGrantCyc;
   int          firstValidCyc;
   int          streamGaps;
   logic        streamPhase;
   logic        sReq;
   logic        sValid;
   logic [31:0] sAddr;
   logic [31:0] sPcd;

   // Memory contents are a fixed scramble of the address, so every word is predictable.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // One clock: drive inputs at the falling edge, sample at +1, advance the model at +3.
   task automatic applyStimulus(input logic rstV, input logic redir, input logic [31:0] tgt,
                                input logic rdy, input logic gntV, input int lat);
      logic respond;
      logic granted;
      int   readyAt;
      @(negedge clk);
      cyc++;
      if (!rstV && prevRst) begin
         memQ.delete();
         lastReady = cyc;
      end
      rst        = rstV;
      PCSrcE     = redir;
      PCTargetE  = tgt;
      ReadyD     = rdy;
      imem_gnt_i = gntV;
      respond    = (memQ.size() > 0) && (memQ[0].readyCyc <= cyc);
      imem_rvalid_i = respond;
      imem_rdata_i  = respond ? memWord(memQ[0].addr) : $urandom;
      #1;
      sReq   = imem_req_o;
      sAddr  = imem_addr_o;
      sValid = ValidD;
      sPcd   = PCD;
      if (rstV) begin
         checkOutput("rst_imem_req", imem_req_o, 0);
         checkOutput("rst_ValidD", ValidD, 0);
         checkOutput("rst_InstrD", InstrD, 0);
         checkOutput("rst_PCD", PCD, 0);
         checkOutput("rst_PCPlus4D", PCPlus4D, 0);
`ifdef FETCH_PERF_CNT_EN
         if (prevRst) begin
            checkOutput("rst_perf_fetched", perf_fetched_o, 0);
            checkOutput("rst_perf_dropped", perf_dropped_o, 0);
         end
`endif
      end else begin
         if (imem_req_o) checkOutput("imem_addr", imem_addr_o, modelPc);
         if (redir) checkOutput("req_during_redirect", imem_req_o, 0);
         if (prevRedir) checkOutput("ValidD_after_redirect", ValidD, 0);
         if (!rdy && ValidD) begin
            checkOutput("head_present", expQ.size() > 0, 1);
            if (expQ.size() > 0) checkOutput("head_pc_stable", PCD, expQ[0].pc);
         end
      end
      granted = imem_req_o && imem_gnt_i;
      #2;
      if (respond) void'(memQ.pop_front());
      if (rstV) begin
         expQ.delete();
         modelPc = RESET_PC;
      end else if (redir) begin
         expQ.delete();
         modelPc = tgt & 32'hFFFF_FFFC;
      end else if (granted) begin
         expQ.push_back('{pc: modelPc, instr: memWord(modelPc)});
         readyAt = cyc + lat;
         if (readyAt <= lastReady) readyAt = lastReady + 1;
         lastReady = readyAt;
         memQ.push_back('{addr: modelPc, readyCyc: readyAt});
         if (firstGrantCyc < 0) firstGrantCyc = cyc;
         modelPc = modelPc + 32'd4;
      end
      prevRst   = rstV;
      prevRedir = redir && !rstV;
   endtask

   // Monitor: every decode handshake consumes the oldest expected entry of the live stream.
   initial begin
      expEntry_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (ValidD && firstValidCyc < 0) firstValidCyc = cyc;
            if (streamPhase && firstValidCyc >= 0 && !ValidD) streamGaps++;
            if (ValidD && ReadyD) begin
               popCnt++;
               checkOutput("pop_has_expected", expQ.size() > 0, 1);
               if (expQ.size() > 0) begin
                  e = expQ.pop_front();
                  checkOutput("PCD", PCD, e.pc);
                  checkOutput("InstrD", InstrD, e.instr);
                  checkOutput("PCPlus4D", PCPlus4D, e.pc + 32'd4);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      int popsBefore;
      rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; ReadyD = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      modelPc = RESET_PC; cyc = 0; lastReady = 0; prevRst = 1'b0; prevRedir = 1'b0;
      checks = 0; fails = 0; popCnt = 0; firstGrantCyc = -1; firstValidCyc = -1;
      streamGaps = 0; streamPhase = 1'b0;

      $display("[TB] reset and first fetch");
      repeat (2) applyStimulus(1, 0, 0, 1, 1, 1);

      $display("[TB] streaming with 1-cycle memory");
      streamPhase = 1'b1;
      repeat (12) applyStimulus(0, 0, 0, 1, 1, 1);
      streamPhase = 1'b0;
      checkOutput("first_valid_latency", firstValidCyc - firstGrantCyc, 2);
      checkOutput("stream_gaps", streamGaps, 0);
      checkOutput("stream_pops_ge_8", popCnt >= 8, 1);

      $display("[TB] decode backpressure");
      repeat (10) applyStimulus(0, 0, 0, 0, 1, 1);
      checkOutput("bp_entries_queued", expQ.size(), FQ_DEPTH);
      checkOutput("bp_req_low", sReq, 0);
      checkOutput("bp_valid_held", sValid, 1);
      popsBefore = popCnt;
      repeat (8) applyStimulus(0, 0, 0, 1, 1, 1);
      checkOutput("bp_drain_pops_ge_4", (popCnt - popsBefore) >= FQ_DEPTH, 1);

      $display("[TB] redirect with two requests in flight");
      g = 0;
      while (memQ.size() != MAX_OUT && g < 20) begin
         applyStimulus(0, 0, 0, 1, 1, 3);
         g++;
      end
      checkOutput("two_in_flight", memQ.size(), MAX_OUT);
      applyStimulus(0, 1, 32'h203, 1, 1, 3);
      g = 0;
      do begin
         applyStimulus(0, 0, 0, 1, 1, 3);
         g++;
      end while (!sReq && g < 20);
      checkOutput("redirect_req_addr", sAddr, 32'h200);
      g = 0;
      while (!sValid && g < 20) begin
         applyStimulus(0, 0, 0, 1, 1, 3);
         g++;
      end
      checkOutput("pcd_after_redirect", sPcd, 32'h200);

      $display("[TB] back-to-back redirects");
      repeat (5) applyStimulus(0, 0, 0, 1, 1, 1);
      applyStimulus(0, 1, 32'h303, 1, 1, 1);
      applyStimulus(0, 1, 32'h400, 1, 1, 1);
      g = 0;
      do begin
         applyStimulus(0, 0, 0, 1, 1, 1);
         g++;
      end while (!sValid && g < 20);
      checkOutput("pcd_after_b2b_redirect", sPcd, 32'h400);

      $display("[TB] randomized traffic");
      repeat (800) begin
         applyStimulus(0, $urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 99) < 70,
                       $urandom_range(0, 99) < 75, $urandom_range(1, 3));
      end

      $display("[TB] reset in the middle of traffic");
      repeat (8) applyStimulus(0, 0, 0, 0, 1, 3);
      repeat (2) applyStimulus(1, 0, 0, 0, 1, 3);
      g = 0;
      do begin
         applyStimulus(0, 0, 0, 1, 1, 1);
         g++;
      end while (!sValid && g < 20);
      checkOutput("pcd_after_reset", sPcd, RESET_PC);

      g = 0;
      while ((expQ.size() != 0 || memQ.size() != 0) && g < 50) begin
         applyStimulus(0, 0, 0, 1, 0, 1);
         g++;
      end
      checkOutput("final_drain", expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
